booth_mult_seq: RTL and testbench

Parametrised sequential Booth multiplier with a single-module interface and a start/busy/done handshake. It generalises the fixed 16-bit signed Booth datapath and controller pair in three ways: any even operand width, a per-operation signed/unsigned mode, and a build-time radix of 2 or 4. It also adds abort and asynchronous reset. It is the arithmetic unit that the datapath's MAC/ALU blocks instantiate.

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_mult_seq_recode.sv | 53 +++++
 rtl/booth_mult_seq.sv | 117 +++++++++++
 tb/tb_booth_mult_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants for the sequential Booth multiplier.
// State encoding, radix-4 digit encoding and iteration count helper.
package booth_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } digit_t;

  // Iterations over the WIDTH+2 bit extended multiplier.
  function automatic int iter_count(input int width, input int radix);
    return (radix == 4) ? (width + 2) / 2 : width + 2;
  endfunction

endpackage

// File: rtl/booth_mult_seq_recode.sv
// Booth recoder: maps the multiplier window to a signed multiple of M.
// Output is one bit wider than M so that +/-2M never overflows.
module booth_recode
  import booth_pkg::*;
#(
  parameter int IW    = 18,
  parameter int RADIX = 2
) (
  input  logic [2:0]  win,
  input  logic [IW-1:0] m,
  output logic [IW:0]   addend
);

  digit_t d2;
  digit_t d4;
  digit_t dig;
  logic [IW:0] me;
  logic [IW:0] me2;

  // Select the Booth digit for the current window.
  always_comb begin
    d2 = ZERO;
    d4 = ZERO;
    unique case (win[1:0])
      2'b01:   d2 = PM;
      2'b10:   d2 = NM;
      default: d2 = ZERO;
    endcase
    unique case (win)
      3'b001, 3'b010: d4 = PM;
      3'b011:         d4 = P2M;
      3'b100:         d4 = N2M;
      3'b101, 3'b110: d4 = NM;
      default:        d4 = ZERO;
    endcase
    dig = (RADIX == 4) ? d4 : d2;
  end

  // Form the selected multiple: choose M or 2M, then negate if needed.
  always_comb begin
    me  = {m[IW-1], m};
    me2 = {m, 1'b0};
    addend = '0;
    unique case (dig)
      PM:      addend = me;
      P2M:     addend = me2;
      NM:      addend = -me;
      N2M:     addend = -me2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, radix 2 or 4, signed or unsigned.
// start/busy/done handshake with abort and asynchronous reset.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADIX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int IW   = WIDTH + 2;
  localparam int AW   = IW + 1;
  localparam int ITER = iter_count(WIDTH, RADIX);
  localparam int CW   = $clog2(ITER + 1);
  localparam int SH   = (RADIX == 4) ? 2 : 1;

  logic [1:0]    state;
  logic [AW-1:0] a;
  logic [IW-1:0] q;
  logic [IW-1:0] m;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [2:0]     win;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  sum;
  logic [AW+IW:0] cat;
  logic [AW+IW:0] sh;
  logic [AW-1:0]  a_n;
  logic [IW-1:0]  q_n;
  logic           qm1_n;
  logic [IW-1:0]  m_ext;
  logic [IW-1:0]  q_ext;

  booth_recode #(
    .IW    (IW),
    .RADIX (RADIX)
  ) u_recode (
    .win    (win),
    .m      (m),
    .addend (addend)
  );

  // One Booth step: add the recoded multiple, then arithmetic shift.
  always_comb begin
    win   = (RADIX == 4) ? {q[1], q[0], qm1} : {1'b0, q[0], qm1};
    sum   = a + addend;
    cat   = {sum, q, qm1};
    sh    = $signed(cat) >>> SH;
    a_n   = sh[AW+IW:IW+1];
    q_n   = sh[IW:1];
    qm1_n = sh[0];
  end

  // Operand extension to the internal width on accept.
  always_comb begin
    m_ext = signed_mode ? {{2{m_in[WIDTH-1]}}, m_in} : {2'b00, m_in};
    q_ext = signed_mode ? {{2{q_in[WIDTH-1]}}, q_in} : {2'b00, q_in};
  end

  // Control FSM, counter and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            a   <= a_n;
            q   <= q_n;
            qm1 <= qm1_n;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              product <= {a_n[2*WIDTH-IW-1:0], q_n};
              state   <= DONE;
            end
          end
        end
        IDLE, DONE: begin
          if (start) begin
            a     <= '0;
            q     <= q_ext;
            m     <= m_ext;
            qm1   <= 1'b0;
            cnt   <= CW'(ITER);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq, radix-2 and radix-4 instances.
// Randomized operands checked against a plain-arithmetic product model.
module tb_booth_mult_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     start_v;
  logic [1:0]     abort_v;
  logic [1:0]     busy_v;
  logic [1:0]     done_v;
  logic           sm;
  logic [W-1:0]   m;
  logic [W-1:0]   q;
  logic [2*W-1:0] prod0;
  logic [2*W-1:0] prod1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W), .RADIX(2)) u_r2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_v[0]),
    .abort       (abort_v[0]),
    .signed_mode (sm),
    .m_in        (m),
    .q_in        (q),
    .busy        (busy_v[0]),
    .done        (done_v[0]),
    .product     (prod0)
  );

  booth_mult_seq #(.WIDTH(W), .RADIX(4)) u_r4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start_v[1]),
    .abort       (abort_v[1]),
    .signed_mode (sm),
    .m_in        (m),
    .q_in        (q),
    .busy        (busy_v[1]),
    .done        (done_v[1]),
    .product     (prod1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
    longint x;
    longint y;
    logic [63:0] p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  function automatic logic [2*W-1:0] prod_of(input int i);
    return (i == 0) ? prod0 : prod1;
  endfunction

  function automatic int iters(input int i);
    return (i == 0) ? W + 2 : (W + 2) / 2;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input int i, input logic [W-1:0] mv,
                        input logic [W-1:0] qv, input logic s);
    m = mv;
    q = qv;
    sm = s;
    start_v[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!done_v[i] && lat < 64) begin
      if (!busy_v[i]) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int i, input logic [W-1:0] mv,
                        input logic [W-1:0] qv, input logic s,
                        input string tag);
    int lat;
    int nb;
    logic [2*W-1:0] exp;
    exp = model(mv, qv, s);
    launch(i, mv, qv, s);
    wait_done(i, lat, nb);
    check({tag, "/prod"}, prod_of(i), exp);
    check({tag, "/lat"}, lat, iters(i));
    check({tag, "/busy"}, nb, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int nb;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] edge_vals [5];
    edge_vals = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};

    rst = 1'b1;
    start_v = '0;
    abort_v = '0;
    sm = 1'b0;
    m = '0;
    q = '0;
    repeat (3) @(negedge clk);
    check("rst/busy", busy_v, 2'b00);
    check("rst/done", done_v, 2'b00);
    check("rst/prod0", prod0, 0);
    check("rst/prod1", prod1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'hFFFC, 16'd5, 1'b1, "r2 -4*5");
    check("r2 -4*5 const", prod0, 32'hFFFFFFEC);
    @(negedge clk);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, "r2 uFFFF^2");
    check("r2 uFFFF^2 const", prod0, 32'hFFFE0001);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, "r2 s-1^2");
    check("r2 s-1^2 const", prod0, 32'h00000001);
    run_op(0, 16'h8000, 16'h8000, 1'b1, "r2 min^2");
    check("r2 min^2 const", prod0, 32'h40000000);
    run_op(0, 16'h8000, 16'h7FFF, 1'b1, "r2 min*max");
    check("r2 min*max const", prod0, 32'hC0008000);
    run_op(0, 16'd8, 16'd0, 1'b1, "r2 8*0");
    check("r2 8*0 const", prod0, 32'h0);

    @(negedge clk);
    run_op(1, 16'd7, 16'hFFFD, 1'b1, "r4 7*-3");
    check("r4 7*-3 const", prod1, 32'hFFFFFFEB);
    run_op(1, 16'hFFFA, 16'hFFFE, 1'b1, "r4 -6*-2");
    check("r4 -6*-2 const", prod1, 32'h0000000C);
    run_op(1, 16'h8000, 16'h8000, 1'b1, "r4 min^2");
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, "r4 uFFFF^2");

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(7) == 0) ra = edge_vals[$urandom_range(4)];
        if ($urandom_range(7) == 0) rb = edge_vals[$urandom_range(4)];
        if ($urandom_range(1) == 1) @(negedge clk);
        run_op(i, ra, rb, 1'($urandom_range(1)), "rand");
      end
    end

    // Abort four cycles in: no done pulse, product unchanged.
    @(negedge clk);
    run_op(0, 16'd3, 16'd5, 1'b0, "pre-abort");
    @(negedge clk);
    launch(0, 16'd100, 16'd100, 1'b0);
    repeat (3) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("abort/busy", busy_v[0], 1'b0);
    check("abort/done", done_v[0], 1'b0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    check("abort/no done", seen, 0);
    check("abort/prod", prod0, 32'd15);

    // Abort while idle is ignored; start beats abort on accept.
    abort_v[0] = 1'b1;
    @(negedge clk);
    check("idle abort/busy", busy_v[0], 1'b0);
    launch(0, 16'd6, 16'd7, 1'b0);
    abort_v[0] = 1'b0;
    wait_done(0, lat, nb);
    check("start wins/prod", prod0, 32'd42);
    check("start wins/lat", lat, 18);

    // Start and operand changes mid-operation are ignored.
    @(negedge clk);
    launch(0, 16'd11, 16'd13, 1'b1);
    repeat (3) @(negedge clk);
    m = 16'd999;
    q = 16'd77;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, lat, nb);
    check("busy start/prod", prod0, 32'd143);
    check("busy start/lat", lat + 4, 18);

    // Back-to-back from the done cycle, then async reset mid-run.
    run_op(0, 16'hFFF9, 16'd9, 1'b1, "b2b first");
    run_op(0, 16'd300, 16'd400, 1'b0, "b2b second");
    check("b2b const", prod0, 32'd120000);
    launch(0, 16'd50, 16'd60, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst/busy", busy_v[0], 1'b0);
    check("async rst/done", done_v[0], 1'b0);
    check("async rst/prod", prod0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 16'd50, 16'd60, 1'b0, "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
